// File: rtl/alu_decode_pkg.sv
// Shared types and helpers for the serial two's-complement decoder.
// Provides the FSM state enum, the cycle-count helper and the default width.
package alu_decode_pkg;

    localparam int DEFAULT_WIDTH = 19;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Number of cycles needed to walk WIDTH bits, BPC bits at a time.
    function automatic int ncyc(input int width, input int bpc);
        return (width + bpc - 1) / bpc;
    endfunction

endpackage

// File: rtl/negate_slice.sv
// Combinational BPC-bit slice of the copy-until-first-one-then-invert rule.
// Ports: chunk (bits, LSB first), neg, seen_one_in -> result, seen_one_out.
module negate_slice #(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] chunk,
    input  logic           neg,
    input  logic           seen_one_in,
    output logic [BPC-1:0] result,
    output logic           seen_one_out
);

    logic seen_acc;

    // Bits are inverted only once a 1 has been passed at a lower position.
    always_comb begin
        seen_acc = seen_one_in;
        result   = '0;
        for (int i = 0; i < BPC; i++) begin
            result[i] = chunk[i] ^ (neg & seen_acc);
            seen_acc  = seen_acc | chunk[i];
        end
        seen_one_out = seen_acc;
    end

endmodule

// File: rtl/serial_negate_decoder.sv
// Multi-cycle two's-complement decoder: sign/magnitude (mode 0) or negate
// (mode 1), BPC bits per cycle, LSB first.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_mode (input handshake),
// out_valid/out_ready/out_data/out_sign/out_ovf (result handshake).
module serial_negate_decoder
    import alu_decode_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sign,
    output logic             out_ovf
);

    localparam int NCYC = ncyc(WIDTH, BPC);
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    // Valid bits in the final chunk.
    localparam int REM  = WIDTH - (NCYC - 1) * BPC;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] oreg;
    logic [WIDTH-1:0] res_ext;
    logic [CW-1:0]    cnt;
    logic [BPC-1:0]   res;
    logic             neg;
    logic             ovf;
    logic             seen_one;
    logic             seen_nx;
    logic             accept;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CW'(NCYC - 1));
    assign res_ext   = WIDTH'(res);

    assign out_data = oreg;
    assign out_sign = neg;
    assign out_ovf  = ovf;

    negate_slice #(
        .BPC(BPC)
    ) u_slice (
        .chunk       (sreg[BPC-1:0]),
        .neg         (neg),
        .seen_one_in (seen_one),
        .result      (res),
        .seen_one_out(seen_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN:  if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Results enter from the MSB side; the last step shifts by only the
    // remaining valid bits so bit 0 of the operand lands at out_data[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg     <= '0;
            oreg     <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
            seen_one <= 1'b0;
        end else if (accept) begin
            sreg     <= in_data;
            neg      <= in_mode | in_data[WIDTH-1];
            ovf      <= in_mode & (in_data == MOST_NEG);
            seen_one <= 1'b0;
            cnt      <= '0;
        end else if (state == RUN) begin
            sreg     <= sreg >> BPC;
            seen_one <= seen_nx;
            cnt      <= cnt + 1'b1;
            if (last) begin
                oreg <= (oreg >> REM) | (res_ext << (WIDTH - REM));
            end else begin
                oreg <= (oreg >> BPC) | (res_ext << (WIDTH - BPC));
            end
        end
    end

endmodule

// File: tb/tb_serial_negate_decoder.sv
// Self-checking bench for serial_negate_decoder at BPC = 1, 3, 4 and 19.
// Directed corner cases plus random transactions against an arithmetic model.
module tb_serial_negate_decoder;

    localparam int W  = 19;
    localparam int NI = 4;

    function automatic int bpc_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 19;
        endcase
    endfunction

    // ceil(19/BPC) for BPC = 1, 3, 4, 19
    int lat_exp [NI] = '{19, 7, 5, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] iv;
    logic [NI-1:0] ir;
    logic [NI-1:0] ov;
    logic [NI-1:0] ordy;
    logic [NI-1:0] os;
    logic [NI-1:0] oo;
    logic [W-1:0]  od [NI];
    logic [W-1:0]  idata;
    logic          imode;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_negate_decoder #(
            .WIDTH(W),
            .BPC  (bpc_of(g))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .in_data  (idata),
            .in_mode  (imode),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .out_data (od[g]),
            .out_sign (os[g]),
            .out_ovf  (oo[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: mode 0 -> |x| with sign = msb; mode 1 -> -x mod 2^W.
    task automatic ref_model(input logic [W-1:0] x, input logic m,
                             output logic [W-1:0] rd, output logic rs,
                             output logic ro);
        int unsigned v;
        int unsigned half;
        int unsigned full;
        v    = x;
        half = 1 << (W - 1);
        full = 1 << W;
        rs   = m | (v >= half);
        rd   = rs ? W'((full - v) % full) : W'(v);
        ro   = m && (v == half);
    endtask

    task automatic run_txn(input int k, input logic [W-1:0] d,
                           input logic m, input int hold,
                           output logic [W-1:0] rd, output logic rs,
                           output logic ro, output int lat);
        int t;
        @(negedge clk);
        idata = d;
        imode = m;
        iv[k] = 1'b1;
        t = 0;
        while (!ir[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", 32'(t < 100), 1);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        idata = W'($urandom);
        imode = 1'($urandom);
        lat = 0;
        while (!ov[k] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = od[k];
        rs = os[k];
        ro = oo[k];
        if (hold > 0) begin
            iv[k] = 1'b1;
            idata = ~d;
            imode = ~m;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(ov[k]), 1);
            check("hold_ready", 32'(ir[k]), 0);
            check("hold_data", 32'(od[k]), 32'(rd));
            check("hold_sign", 32'(os[k]), 32'(rs));
            check("hold_ovf", 32'(oo[k]), 32'(ro));
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        check("drop_valid", 32'(ov[k]), 0);
        check("idle_ready", 32'(ir[k]), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rd;
        logic [W-1:0] md;
        logic         rs;
        logic         ro;
        logic         ms;
        logic         mo;
        logic [W-1:0] d;
        logic         m;
        int           lat;
        int           k;

        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        idata = '0;
        imode = 1'b0;
        #12;
        check("rst_ready", 32'(ir[0]), 1);
        check("rst_valid", 32'(ov[0]), 0);
        check("rst_data", 32'(od[0]), 0);
        check("rst_sign", 32'(os[0]), 0);
        check("rst_ovf", 32'(oo[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(0, 19'h7FFFB, 1'b0, 0, rd, rs, ro, lat);
        check("neg5_data", 32'(rd), 32'h5);
        check("neg5_sign", 32'(rs), 1);
        check("neg5_ovf", 32'(ro), 0);
        check("neg5_lat", 32'(lat), 19);

        run_txn(2, 19'h0002A, 1'b0, 0, rd, rs, ro, lat);
        check("pos42_data", 32'(rd), 32'h2A);
        check("pos42_sign", 32'(rs), 0);
        check("pos42_lat", 32'(lat), 5);

        run_txn(2, 19'h0002A, 1'b1, 0, rd, rs, ro, lat);
        check("neg42_data", 32'(rd), 32'h7FFD6);
        check("neg42_sign", 32'(rs), 1);

        run_txn(2, 19'h40000, 1'b0, 0, rd, rs, ro, lat);
        check("mn_m0_data", 32'(rd), 32'h40000);
        check("mn_m0_sign", 32'(rs), 1);
        check("mn_m0_ovf", 32'(ro), 0);

        run_txn(2, 19'h40000, 1'b1, 0, rd, rs, ro, lat);
        check("mn_m1_data", 32'(rd), 32'h40000);
        check("mn_m1_sign", 32'(rs), 1);
        check("mn_m1_ovf", 32'(ro), 1);

        run_txn(2, 19'h00000, 1'b1, 0, rd, rs, ro, lat);
        check("zero_m1_data", 32'(rd), 0);
        check("zero_m1_sign", 32'(rs), 1);
        check("zero_m1_ovf", 32'(ro), 0);

        run_txn(3, 19'h00000, 1'b0, 0, rd, rs, ro, lat);
        check("zero_m0_sign", 32'(rs), 0);
        check("zero_m0_lat", 32'(lat), 1);

        // Backpressure with a competing in_valid held during DONE.
        run_txn(1, 19'h12345, 1'b0, 10, rd, rs, ro, lat);
        check("bp_data", 32'(rd), 32'h12345);
        check("bp_sign", 32'(rs), 0);
        check("bp_lat", 32'(lat), 7);

        // Reset while RUN at cnt = 7.
        @(negedge clk);
        idata = 19'h55555;
        imode = 1'b1;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("run_busy", 32'(ir[0]), 0);
        rst_n = 1'b0;
        #1;
        check("rrun_valid", 32'(ov[0]), 0);
        check("rrun_ready", 32'(ir[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(0, 19'h00001, 1'b1, 0, rd, rs, ro, lat);
        check("one_m1_data", 32'(rd), 32'h7FFFF);
        check("one_m1_sign", 32'(rs), 1);
        check("one_m1_lat", 32'(lat), 19);

        // Reset while DONE: out_valid must fall without a clock edge.
        @(negedge clk);
        idata = 19'h00123;
        imode = 1'b0;
        iv[2] = 1'b1;
        @(posedge clk);
        #1;
        iv[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("done_valid", 32'(ov[2]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rdone_valid", 32'(ov[2]), 0);
        check("rdone_ready", 32'(ir[2]), 1);
        check("rdone_data", 32'(od[2]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            k = int'($urandom % 3);
            if (k == 2) k = 3;
            case ($urandom % 10)
                0:       d = 19'h40000;
                1:       d = 19'h00000;
                2:       d = 19'h7FFFF;
                3:       d = 19'h00001;
                default: d = W'($urandom);
            endcase
            m = 1'($urandom);
            ref_model(d, m, md, ms, mo);
            run_txn(k, d, m, 0, rd, rs, ro, lat);
            check("rnd_data", 32'(rd), 32'(md));
            check("rnd_sign", 32'(rs), 32'(ms));
            check("rnd_ovf", 32'(ro), 32'(mo));
            check("rnd_lat", 32'(lat), 32'(lat_exp[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_negate_decoder.md
Name: serial_negate_decoder

Overview:
- Multi-cycle two's-complement decoder for the Execute/ALU path; pairs with the operand-complementing side of the adder.
- Takes a WIDTH-bit two's-complement result and returns sign plus unsigned magnitude (mode 0), or the arithmetic negation (mode 1).
- Processes BPC bits per cycle, LSB first, using a copy-until-first-one-then-invert rule, so no wide adder is needed.
- valid/ready handshake on both sides; one transaction in flight at a time.

Parameters:
- WIDTH, 19, data width in bits (>= 2).
- BPC, 1, bits processed per cycle (1..WIDTH). NCYC = ceil(WIDTH/BPC).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction offered.
- in_ready  out  1  block can accept.
- in_data  in  WIDTH  two's-complement operand.
- in_mode  in  1  0 = sign/magnitude decode; 1 = unconditional negate.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  magnitude (mode 0) or negated value (mode 1).
- out_sign  out  1  1 iff negation was applied.
- out_ovf  out  1  mode 1 with in_data = most-negative value.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_sign=0, out_ovf=0, counters and shift register = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_data into the shift register and set neg = in_mode | in_data[WIDTH-1].
  - Latch ovf = in_mode & (in_data == 1 followed by WIDTH-1 zeros).
  - Clear seen_one and cnt, then go to RUN.
- RUN:
  - in_ready=0. Each cycle, process BPC bits from the LSB end.
  - Per bit b: if neg, o = seen_one ? ~b : b, else o = b. Then seen_one |= b, sequentially within the chunk.
  - Result bits shift into the output register from the MSB side.
  - In the last chunk, bit positions >= WIDTH are ignored and the output is aligned so out_data[0] is the original bit 0.
  - cnt increments each cycle; when cnt = NCYC-1, go to DONE.
- DONE:
  - out_valid=1; out_data, out_sign=neg, out_ovf=ovf are held stable while out_ready=0.
  - On out_ready: go to IDLE with out_valid=0. The first in_valid is accepted no earlier than the cycle after.
- Latency: out_valid rises exactly NCYC cycles after the accepting edge. Throughput: one result per NCYC+2 cycles minimum.
- in_data and in_mode are sampled only at the accept edge; later changes are ignored.
- Mode 0, most-negative input (100..0): out_data = 100..0 read as unsigned 2^(WIDTH-1), out_sign=1, out_ovf=0.
- Mode 1, most-negative input: out_data = 100..0, out_sign=1, out_ovf=1.
- Zero input: out_data=0, out_ovf=0; out_sign = in_mode.
- in_valid while not IDLE: ignored; in_ready=0 guarantees no acceptance.
- rst_n low in RUN or DONE: immediate return to IDLE, out_valid drops asynchronously, and the transaction is discarded.

Decomposition:
- Shared package alu_decode_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - function ncyc(WIDTH, BPC) returning the ceiling division
  - constant for the default WIDTH=19
- One combinational sub-module, negate_slice, with parameter BPC:
  - inputs: chunk bits, neg, seen_one_in
  - outputs: result bits, seen_one_out
- The top level owns the FSM, counter, and shift registers.

Test Plan:
- WIDTH=19, BPC=1, in_data=0x7FFFB, mode 0 -> out_data=0x00005, out_sign=1, out_ovf=0; out_valid exactly 19 cycles after accept.
- BPC=4, in_data=0x0002A, mode 0 -> out_data=0x0002A, out_sign=0; latency 5 cycles. Same input in mode 1 -> out_data=0x7FFD6, out_sign=1.
- in_data=0x40000 -> mode 0: out_data=0x40000, sign=1, ovf=0. mode 1: out_data=0x40000, ovf=1. in_data=0, mode 1: out_data=0, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is not accepted. Release -> one handshake, then IDLE.
- Deassert rst_n mid-RUN (cnt=7, BPC=1) -> out_valid=0 and in_ready=1 immediately. The next transaction 0x00001 in mode 1 yields 0x7FFFF.
- Random 1000 back-to-back transactions at BPC in {1,3,19}, checked against a model (mode 0: sign=msb, mag=|x|; mode 1: -x mod 2^19).
